// File: rtl/wb_write_ctrl.sv
// wb_write_ctrl: MEM/WB register plus long-latency result queue merged onto the single register-file write port
module wb_write_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             mem_wd,
  input  logic                          mem_wreg,
  input  logic [DATA_W-1:0]             mem_wdata,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [ADDR_W-1:0]             lu_waddr,
  input  logic [DATA_W-1:0]             lu_wdata,
  output logic                          we,
  output logic [ADDR_W-1:0]             waddr,
  output logic [DATA_W-1:0]             wdata,
  input  logic [ADDR_W-1:0]             chk_addr,
  output logic                          chk_pending,
  output logic                          stall_req,
  output logic [$clog2(LQ_DEPTH):0]     lq_count
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic              wb_wreg;
  logic [ADDR_W-1:0] wb_wd;
  logic [DATA_W-1:0] wb_wdata;
  logic [ADDR_W-1:0] q_addr [LQ_DEPTH];
  logic [DATA_W-1:0] q_data [LQ_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve, starve_n;
  logic              pipe_valid, q_nonempty, pop, push;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wreg  <= 1'b0;
      wb_wd    <= '0;
      wb_wdata <= '0;
    end else if (flush) begin
      wb_wreg <= 1'b0;
    end else if (!stall) begin
      wb_wreg  <= mem_wreg;
      wb_wd    <= mem_wd;
      wb_wdata <= mem_wdata;
    end
  end

  // Pipeline owns the port; the queue only fills slots the pipeline leaves idle.
  always_comb begin
    pipe_valid = wb_wreg && wb_wd != '0 && !stall;
    q_nonempty = count != '0;
    pop        = !rst && !pipe_valid && q_nonempty;
    we         = !rst && (pipe_valid || q_nonempty);
    waddr      = rst ? '0 : pipe_valid ? wb_wd : q_nonempty ? q_addr[rd_ptr] : '0;
    wdata      = rst ? '0 : pipe_valid ? wb_wdata : q_nonempty ? q_data[rd_ptr] : '0;
    lu_ready   = !rst && count < CW'(LQ_DEPTH);
    push       = lu_valid && lu_ready && lu_waddr != '0;
    starve_n   = (pop || !q_nonempty) ? '0 : (starve == SW'(STARVE_LIMIT)) ? starve : starve + 1'b1;
    lq_count   = count;
  end

  always_comb begin
    logic [PW-1:0] off;
    chk_pending = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if ({1'b0, off} < count && q_addr[i] == chk_addr && chk_addr != '0) chk_pending = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= lu_waddr;
      q_data[wr_ptr] <= lu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      starve    <= '0;
      stall_req <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count     <= count + CW'(push) - CW'(pop);
      starve    <= starve_n;
      stall_req <= starve_n == SW'(STARVE_LIMIT);
    end
  end
endmodule
